// File: rtl/sram_responder.sv
// sram_responder
//   On-chip replacement for the SLC-3 external SRAM. After reset it copies
//   INIT_WORDS words from a program ROM and zero-fills the rest of the array.
//   Only then does it serve CPU reads and writes.
//
// Ports
//   Clk, Reset          : clock, asynchronous active-low reset
//   ADDR, OE, WE        : CPU request (word address, active-low enables)
//   Data_to_SRAM        : write data
//   Data_from_SRAM      : registered read data (1-cycle latency)
//   Init_Addr/Init_Data : ROM port (ROM data is valid one cycle after address)
//   Init_Done           : high once serving
//   Range_Err           : sticky, an access hit ADDR >= 2^ADDR_W
//   Conflict_Err        : sticky, OE and WE were both low while serving
//   dbg_state           : current FSM state (LOAD=0, CLEAR=1, SERVE=2)
//
// Bus protocol: there is no handshake. Every SERVE edge samples OE/WE/ADDR
// and acts on them; requests seen in LOAD or CLEAR are dropped silently.
module sram_responder #(
  parameter int ADDR_W     = 10,
  parameter int INIT_WORDS = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic [ADDR_W-1:0] Init_Addr,
  input  logic [15:0]       Init_Data,
  output logic              Init_Done,
  output logic              Range_Err,
  output logic              Conflict_Err,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(INIT_WORDS - 1);
  localparam logic [ADDR_W-1:0] CLR_START = ADDR_W'(INIT_WORDS % DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;  // address presented to the ROM
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;   // address whose ROM word arrives now
  logic              pend_q,     pend_d;      // ROM pipeline holds a valid word
  logic [ADDR_W-1:0] clr_cnt_q,  clr_cnt_d;
  logic [15:0]       data_q,     data_d;
  logic              done_q,     done_d;
  logic              rerr_q,     rerr_d;
  logic              cerr_q,     cerr_d;

  logic [15:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  logic              in_range;
  logic [ADDR_W-1:0] bus_idx;

  assign in_range = ((ADDR >> ADDR_W) == 16'd0);
  assign bus_idx  = ADDR[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    wr_addr_d  = wr_addr_q;
    pend_d     = pend_q;
    clr_cnt_d  = clr_cnt_q;
    data_d     = 16'h0000;
    done_d     = done_q;
    rerr_d     = rerr_q;
    cerr_d     = cerr_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = 16'h0000;

    unique case (state_q)
      ST_LOAD: begin
        // The ROM word for the previous address lands this cycle.
        wr_addr_d = load_cnt_q;
        pend_d    = 1'b1;
        if (load_cnt_q != LAST_INIT) begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
        if (pend_q) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr_q;
          mem_wdata = Init_Data;
          if (wr_addr_q == LAST_INIT) begin
            if (INIT_WORDS == DEPTH) begin
              state_d = ST_SERVE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_CLEAR;
            end
          end
        end
      end

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = 16'h0000;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_SERVE;
          done_d  = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      ST_SERVE: begin
        if (!WE) begin
          if (in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bus_idx;
            mem_wdata = Data_to_SRAM;
          end else begin
            rerr_d = 1'b1;
          end
          // Simultaneous OE: the write wins, read data is forced to zero.
          if (!OE) begin
            cerr_d = 1'b1;
          end
        end else if (!OE) begin
          if (in_range) begin
            data_d = mem[bus_idx];
          end else begin
            rerr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      wr_addr_q  <= '0;
      pend_q     <= 1'b0;
      clr_cnt_q  <= CLR_START;
      data_q     <= 16'h0000;
      done_q     <= 1'b0;
      rerr_q     <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      wr_addr_q  <= wr_addr_d;
      pend_q     <= pend_d;
      clr_cnt_q  <= clr_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
      rerr_q     <= rerr_d;
      cerr_q     <= cerr_d;
    end
  end

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign Data_from_SRAM = data_q;
  assign Init_Addr      = load_cnt_q;
  assign Init_Done      = done_q;
  assign Range_Err      = rerr_q;
  assign Conflict_Err   = cerr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Directed bench for sram_responder with default parameters. A registered
//   ROM model returns 0x3000+addr one cycle after Init_Addr.
module tb_sram_responder;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [15:0]       addr;
  logic              oe;
  logic              we;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic [ADDR_W-1:0] init_addr;
  logic [15:0]       init_data;
  logic              init_done;
  logic              range_err;
  logic              conflict_err;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int cycles;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(ADDR_W), .INIT_WORDS(64)) dut (
    .Clk            (clk),
    .Reset          (rst_n),
    .ADDR           (addr),
    .OE             (oe),
    .WE             (we),
    .Data_to_SRAM   (wdata),
    .Data_from_SRAM (rdata),
    .Init_Addr      (init_addr),
    .Init_Data      (init_data),
    .Init_Done      (init_done),
    .Range_Err      (range_err),
    .Conflict_Err   (conflict_err),
    .dbg_state      (dbg_state)
  );

  // Synchronous program ROM: word k = 0x3000 + k
  always @(posedge clk) init_data <= 16'h3000 + {6'd0, init_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one bus cycle, inputs set on negedge, outputs sampled after posedge
  task automatic bus(input logic oe_n, input logic we_n, input logic [15:0] a,
                     input logic [15:0] d);
    @(negedge clk);
    oe = oe_n; we = we_n; addr = a; wdata = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    oe = 1'b1; we = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    oe = 1'b0; we = 1'b1; addr = a;
    @(posedge clk);
    #1;
    check(tag, {16'd0, rdata}, {16'd0, exp});
    oe = 1'b1;
  endtask

  // Release reset and count edges to Init_Done; the bus attempts a
  // conflicting write to address 3 during the first 20 cycles.
  task automatic preload(input string tag);
    @(negedge clk);
    oe = 1'b0; we = 1'b0; addr = 16'h0003; wdata = 16'hDEAD;
    rst_n = 1'b1;
    cycles = 0;
    while (!init_done && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 20) begin
        check({tag, "_load_data"}, {16'd0, rdata}, 32'h0);
        check({tag, "_load_cerr"}, {31'd0, conflict_err}, 32'h0);
        oe = 1'b1; we = 1'b1;
      end
    end
    check({tag, "_done_cycles"}, cycles, 32'd1025);
    check({tag, "_flags"}, {30'd0, range_err, conflict_err}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    oe = 1'b1; we = 1'b1; addr = 16'h0; wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {16'd0, rdata}, 32'h0);
    check("rst_init_addr", {22'd0, init_addr}, 32'h0);
    check("rst_outs", {29'd0, init_done, range_err, conflict_err}, 32'h0);

    preload("pre1");

    rd("rd_5", 16'h0005, 16'h3005);
    rd("rd_5_hold", 16'h0005, 16'h3005);
    rd("rd_100", 16'h0064, 16'h0000);
    rd("rd_3_ignored", 16'h0003, 16'h3003);
    rd("rd_63", 16'h003F, 16'h303F);
    rd("rd_64", 16'h0040, 16'h0000);
    rd("rd_1023", 16'h03FF, 16'h0000);

    // idle returns zero
    @(negedge clk);
    @(posedge clk);
    #1;
    check("idle_data", {16'd0, rdata}, 32'h0);

    bus(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    rd("rd_10_new", 16'h0010, 16'hBEEF);
    rd("rd_0f", 16'h000F, 16'h300F);
    rd("rd_11", 16'h0011, 16'h3011);
    check("no_rerr", {31'd0, range_err}, 32'h0);

    bus(1'b1, 1'b0, 16'h0400, 16'h1234);
    check("oor_wr_rerr", {31'd0, range_err}, 32'h1);
    rd("rd_400", 16'h0400, 16'h0000);
    rd("rd_0_alias", 16'h0000, 16'h3000);
    check("no_cerr", {31'd0, conflict_err}, 32'h0);

    @(negedge clk);
    oe = 1'b0; we = 1'b0; addr = 16'h0020; wdata = 16'h5555;
    @(posedge clk);
    #1;
    check("conf_data", {16'd0, rdata}, 32'h0);
    check("conf_cerr", {31'd0, conflict_err}, 32'h1);
    oe = 1'b1; we = 1'b1;
    rd("rd_20_new", 16'h0020, 16'h5555);
    check("flags_sticky", {30'd0, range_err, conflict_err}, 32'h3);

    // asynchronous reset mid-SERVE, asserted away from a clock edge
    rd("rd_pre_rst", 16'h0005, 16'h3005);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", {16'd0, rdata}, 32'h0);
    check("arst_outs", {29'd0, init_done, range_err, conflict_err}, 32'h0);
    check("arst_state", {30'd0, dbg_state}, 32'h0);
    repeat (2) @(posedge clk);

    preload("pre2");
    rd("rd_10_reload", 16'h0010, 16'h3010);
    rd("rd_20_reload", 16'h0020, 16'h3020);
    rd("rd_100_reload", 16'h0064, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
